// File: rtl/ram32x4_arbiter.sv
// Round-robin two-port front end for the 32x4 registered-input RAM: clears the
// array after reset, then grants one command per clock with a 2-cycle read return.
module ram32x4_arbiter #(
    parameter int                    ADDR_WIDTH  = 5,
    parameter int                    DATA_WIDTH  = 4,
    parameter bit                    INIT_ENABLE = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = {DATA_WIDTH{1'b0}}
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Req0,
    input  logic                  Wr0,
    input  logic [ADDR_WIDTH-1:0] Addr0,
    input  logic [DATA_WIDTH-1:0] WData0,
    output logic                  Gnt0,
    output logic                  RValid0,
    output logic [DATA_WIDTH-1:0] RData0,
    input  logic                  Req1,
    input  logic                  Wr1,
    input  logic [ADDR_WIDTH-1:0] Addr1,
    input  logic [DATA_WIDTH-1:0] WData1,
    output logic                  Gnt1,
    output logic                  RValid1,
    output logic [DATA_WIDTH-1:0] RData1,
    output logic                  Busy,
    output logic [ADDR_WIDTH-1:0] RamAddress,
    output logic [DATA_WIDTH-1:0] RamData,
    output logic                  RamWrite,
    input  logic [DATA_WIDTH-1:0] RamQ
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [0:0] ST_RST  = INIT_ENABLE ? ST_INIT : ST_RUN;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  ptr_q, ptr_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
    logic                  ram_wr_q, ram_wr_d;
    logic                  s1_vld_q, s1_vld_d;
    logic                  s1_own_q, s1_own_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic                  gnt0_s, gnt1_s;

    // Arbitration: a lone requester wins; on contention the pointer decides.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (state_q == ST_RUN) begin
            gnt0_s = Req0 && (!Req1 || !ptr_q);
            gnt1_s = Req1 && (!Req0 || ptr_q);
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Next-state logic for the sweep, RAM command registers and read-return pipe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_wr_d   = 1'b0;
        s1_vld_d   = 1'b0;
        s1_own_d   = s1_own_q;
        rvalid0_d  = s1_vld_q && !s1_own_q;
        rvalid1_d  = s1_vld_q && s1_own_q;
        case (state_q)
            ST_INIT: begin
                ram_wr_d   = 1'b1;
                ram_addr_d = cnt_q;
                ram_data_d = INIT_VALUE;
                cnt_d      = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_INIT;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                // Reads keep the last write data on the RAM data bus.
                if (gnt0_s) begin
                    ram_addr_d = Addr0;
                    ram_wr_d   = Wr0;
                    ram_data_d = Wr0 ? WData0 : ram_data_q;
                    s1_vld_d   = !Wr0;
                    s1_own_d   = 1'b0;
                    ptr_d      = 1'b1;
                end else if (gnt1_s) begin
                    ram_addr_d = Addr1;
                    ram_wr_d   = Wr1;
                    ram_data_d = Wr1 ? WData1 : ram_data_q;
                    s1_vld_d   = !Wr1;
                    s1_own_d   = 1'b1;
                    ptr_d      = 1'b0;
                end else begin
                    ram_wr_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_RST;
                busy_d  = INIT_ENABLE;
                cnt_d   = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    // State and output registers; reset also flushes in-flight reads.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_RST;
            cnt_q      <= {ADDR_WIDTH{1'b0}};
            ptr_q      <= 1'b0;
            busy_q     <= INIT_ENABLE;
            ram_addr_q <= {ADDR_WIDTH{1'b0}};
            ram_data_q <= {DATA_WIDTH{1'b0}};
            ram_wr_q   <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_own_q   <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_wr_q   <= ram_wr_d;
            s1_vld_q   <= s1_vld_d;
            s1_own_q   <= s1_own_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end

    assign Gnt0       = gnt0_s;
    assign Gnt1       = gnt1_s;
    assign Busy       = busy_q;
    assign RamAddress = ram_addr_q;
    assign RamData    = ram_data_q;
    assign RamWrite   = ram_wr_q;
    assign RValid0    = rvalid0_q;
    assign RValid1    = rvalid1_q;
    assign RData0     = rvalid0_q ? RamQ : {DATA_WIDTH{1'b0}};
    assign RData1     = rvalid1_q ? RamQ : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_ram32x4_arbiter.sv
// Directed bench for ram32x4_arbiter with a behavioural ram32x4 behind it;
// a second instance covers INIT_ENABLE=0.
module tb_ram32x4_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
    logic [4:0] addr0 = 5'd0, addr1 = 5'd0;
    logic [3:0] wdata0 = 4'd0, wdata1 = 4'd0;
    logic       gnt0, gnt1, rvalid0, rvalid1, busy, ram_write;
    logic [3:0] rdata0, rdata1, ram_data, ram_q;
    logic [4:0] ram_address;

    logic       rst2 = 1'b1;
    logic       n_req1 = 1'b0, n_wr1 = 1'b0;
    logic [4:0] n_addr1 = 5'd0;
    logic [3:0] n_wdata1 = 4'd0;
    logic       n_gnt0, n_gnt1, n_rvalid0, n_rvalid1, n_busy, n_ram_write;
    logic [3:0] n_rdata0, n_rdata1, n_ram_data;
    logic [4:0] n_ram_address;
    logic [3:0] n_ram_q = 4'd0;
    logic       n_zero = 1'b0;
    logic [4:0] n_zaddr = 5'd0;
    logic [3:0] n_zdata = 4'd0;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] mem [0:31];
    logic [4:0] ram_addr_r = 5'd0;

    always #5 clk = ~clk;

    initial for (int i = 0; i < 32; i++) mem[i] = 4'hF;

    // ram32x4 model: inputs registered on the edge, q unregistered
    always @(posedge clk) begin
        if (ram_write) mem[ram_address] <= ram_data;
        ram_addr_r <= ram_address;
    end
    assign ram_q = mem[ram_addr_r];

    ram32x4_arbiter u_dut (
        .Clock(clk), .Reset(rst),
        .Req0(req0), .Wr0(wr0), .Addr0(addr0), .WData0(wdata0),
        .Gnt0(gnt0), .RValid0(rvalid0), .RData0(rdata0),
        .Req1(req1), .Wr1(wr1), .Addr1(addr1), .WData1(wdata1),
        .Gnt1(gnt1), .RValid1(rvalid1), .RData1(rdata1),
        .Busy(busy), .RamAddress(ram_address), .RamData(ram_data),
        .RamWrite(ram_write), .RamQ(ram_q)
    );

    ram32x4_arbiter #(.INIT_ENABLE(1'b0)) u_dut_noinit (
        .Clock(clk), .Reset(rst2),
        .Req0(n_zero), .Wr0(n_zero), .Addr0(n_zaddr), .WData0(n_zdata),
        .Gnt0(n_gnt0), .RValid0(n_rvalid0), .RData0(n_rdata0),
        .Req1(n_req1), .Wr1(n_wr1), .Addr1(n_addr1), .WData1(n_wdata1),
        .Gnt1(n_gnt1), .RValid1(n_rvalid1), .RData1(n_rdata1),
        .Busy(n_busy), .RamAddress(n_ram_address), .RamData(n_ram_data),
        .RamWrite(n_ram_write), .RamQ(n_ram_q)
    );

    task automatic test_reset;
        logic exp_v;
        int   j;
        rst = 1'b1; req0 = 1'b1; wr0 = 1'b0; addr0 = 5'd0;
        @(posedge clk); @(posedge clk); #1;
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL rst_busy: got %b want 1", busy); end
        compared++; if (ram_write !== 1'b0) begin mismatched++; $display("FAIL rst_ramwrite: got %b want 0", ram_write); end
        compared++; if (ram_address !== 5'd0) begin mismatched++; $display("FAIL rst_ramaddr: got %0d want 0", ram_address); end
        compared++; if (gnt0 !== 1'b0) begin mismatched++; $display("FAIL rst_gnt0: got %b want 0", gnt0); end
        compared++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin mismatched++; $display("FAIL rst_rvalid: got %b%b want 00", rvalid0, rvalid1); end
        rst = 1'b0;
        #1;
        compared++; if (gnt0 !== 1'b0) begin mismatched++; $display("FAIL init_gnt0_first: got %b want 0", gnt0); end
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            compared++; if (ram_write !== 1'b1) begin mismatched++; $display("FAIL init_wr[%0d]: got %b want 1", k, ram_write); end
            compared++; if (ram_address !== 5'(k)) begin mismatched++; $display("FAIL init_addr[%0d]: got %0d want %0d", k, ram_address, k); end
            compared++; if (ram_data !== 4'd0) begin mismatched++; $display("FAIL init_data[%0d]: got %h want 0", k, ram_data); end
            compared++; if (busy !== (k < 31)) begin mismatched++; $display("FAIL init_busy[%0d]: got %b want %b", k, busy, k < 31); end
            compared++; if (gnt0 !== (k == 31)) begin mismatched++; $display("FAIL init_gnt0[%0d]: got %b want %b", k, gnt0, k == 31); end
        end
        // read back every word; data appears two cycles after acceptance
        for (int c = 0; c < 34; c++) begin
            req0 = (c < 32); addr0 = 5'(c);
            #1;
            if (c < 32) begin
                compared++; if (gnt0 !== 1'b1) begin mismatched++; $display("FAIL scan_gnt0[%0d]: got %b want 1", c, gnt0); end
            end
            j = c - 2;
            exp_v = (j >= 0);
            compared++; if (rvalid0 !== exp_v) begin mismatched++; $display("FAIL scan_rvalid0[%0d]: got %b want %b", c, rvalid0, exp_v); end
            compared++; if (rdata0 !== 4'd0) begin mismatched++; $display("FAIL scan_rdata0[%0d]: got %h want 0", c, rdata0); end
            compared++; if (rvalid1 !== 1'b0) begin mismatched++; $display("FAIL scan_rvalid1[%0d]: got %b want 0", c, rvalid1); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_write_read;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 5'd5; wdata0 = 4'hA;
        #1;
        compared++; if (gnt0 !== 1'b1) begin mismatched++; $display("FAIL wr_gnt0: got %b want 1", gnt0); end
        @(posedge clk); #1;
        wr0 = 1'b0;
        #1;
        compared++; if (gnt0 !== 1'b1) begin mismatched++; $display("FAIL rd_gnt0: got %b want 1", gnt0); end
        compared++; if (ram_write !== 1'b1 || ram_address !== 5'd5 || ram_data !== 4'hA) begin mismatched++; $display("FAIL wr_ramcmd: got w%b a%0d d%h want w1 a5 dA", ram_write, ram_address, ram_data); end
        @(posedge clk); #1;
        req0 = 1'b0;
        compared++; if (ram_write !== 1'b0 || ram_address !== 5'd5 || ram_data !== 4'hA) begin mismatched++; $display("FAIL rd_ramcmd: got w%b a%0d d%h want w0 a5 dA", ram_write, ram_address, ram_data); end
        compared++; if (rvalid0 !== 1'b0) begin mismatched++; $display("FAIL rd_early: got %b want 0", rvalid0); end
        @(posedge clk); #1;
        compared++; if (rvalid0 !== 1'b1 || rdata0 !== 4'hA) begin mismatched++; $display("FAIL rd_return: got v%b d%h want v1 dA", rvalid0, rdata0); end
        compared++; if (rvalid1 !== 1'b0) begin mismatched++; $display("FAIL rd_rvalid1: got %b want 0", rvalid1); end
        @(posedge clk); #1;
        compared++; if (rvalid0 !== 1'b0 || rdata0 !== 4'h0) begin mismatched++; $display("FAIL rd_pulse: got v%b d%h want v0 d0", rvalid0, rdata0); end
    endtask

    task automatic test_round_robin;
        logic exp_g0, exp_g1, exp_v0, exp_v1;
        int   j;
        // port 1 writes 6 to address 7, leaving the pointer on port 0
        req1 = 1'b1; wr1 = 1'b1; addr1 = 5'd7; wdata1 = 4'h6;
        #1;
        compared++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin mismatched++; $display("FAIL rr_setup: got g0=%b g1=%b want 0 1", gnt0, gnt1); end
        @(posedge clk); #1;
        for (int c = 0; c < 12; c++) begin
            req0 = (c < 10); req1 = (c < 6); wr0 = 1'b0; wr1 = 1'b0; addr0 = 5'd5; addr1 = 5'd7;
            #1;
            exp_g0 = (c < 6) ? (c % 2 == 0) : (c < 10);
            exp_g1 = (c < 6) && (c % 2 == 1);
            compared++; if (gnt0 !== exp_g0 || gnt1 !== exp_g1) begin mismatched++; $display("FAIL rr_gnt[%0d]: got %b%b want %b%b", c, gnt0, gnt1, exp_g0, exp_g1); end
            j = c - 2;
            exp_v0 = (j >= 0) && (j < 10) && ((j >= 6) || (j % 2 == 0));
            exp_v1 = (j >= 0) && (j < 6) && (j % 2 == 1);
            compared++; if (rvalid0 !== exp_v0 || rvalid1 !== exp_v1) begin mismatched++; $display("FAIL rr_rvalid[%0d]: got %b%b want %b%b", c, rvalid0, rvalid1, exp_v0, exp_v1); end
            compared++; if (rdata0 !== (exp_v0 ? 4'hA : 4'h0) || rdata1 !== (exp_v1 ? 4'h6 : 4'h0)) begin mismatched++; $display("FAIL rr_rdata[%0d]: got %h %h want %h %h", c, rdata0, rdata1, exp_v0 ? 4'hA : 4'h0, exp_v1 ? 4'h6 : 4'h0); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_contention_write;
        // pointer favours port 1 after the last port-0 grant
        req0 = 1'b1; wr0 = 1'b1; addr0 = 5'd31; wdata0 = 4'h3;
        req1 = 1'b1; wr1 = 1'b1; addr1 = 5'd31; wdata1 = 4'hC;
        #1;
        compared++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin mismatched++; $display("FAIL cw_first: got g0=%b g1=%b want 0 1", gnt0, gnt1); end
        @(posedge clk); #1;
        req1 = 1'b0;
        #1;
        compared++; if (gnt0 !== 1'b1) begin mismatched++; $display("FAIL cw_second: got %b want 1", gnt0); end
        compared++; if (ram_write !== 1'b1 || ram_address !== 5'd31 || ram_data !== 4'hC) begin mismatched++; $display("FAIL cw_cmd1: got w%b a%0d d%h want w1 a31 dC", ram_write, ram_address, ram_data); end
        @(posedge clk); #1;
        wr0 = 1'b0;
        compared++; if (ram_write !== 1'b1 || ram_data !== 4'h3) begin mismatched++; $display("FAIL cw_cmd0: got w%b d%h want w1 d3", ram_write, ram_data); end
        @(posedge clk); #1;
        req0 = 1'b0;
        @(posedge clk); #1;
        compared++; if (rvalid0 !== 1'b1 || rdata0 !== 4'h3) begin mismatched++; $display("FAIL cw_readback: got v%b d%h want v1 d3", rvalid0, rdata0); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_read;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 5'd5;
        #1;
        compared++; if (gnt0 !== 1'b1) begin mismatched++; $display("FAIL mr_gnt0: got %b want 1", gnt0); end
        @(posedge clk); #1;
        req0 = 1'b0;
        rst = 1'b1;
        #1;
        compared++; if (busy !== 1'b1 || ram_write !== 1'b0 || ram_address !== 5'd0) begin mismatched++; $display("FAIL mr_reset: got b%b w%b a%0d want b1 w0 a0", busy, ram_write, ram_address); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            compared++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin mismatched++; $display("FAIL mr_rvalid[%0d]: got %b%b want 00", k, rvalid0, rvalid1); end
        end
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            compared++; if (rvalid0 !== 1'b0) begin mismatched++; $display("FAIL mr_sweep_rvalid[%0d]: got %b want 0", k, rvalid0); end
            if (k < 2) begin
                compared++; if (ram_write !== 1'b1 || ram_address !== 5'(k) || busy !== 1'b1) begin mismatched++; $display("FAIL mr_sweep[%0d]: got w%b a%0d b%b want w1 a%0d b1", k, ram_write, ram_address, busy, k); end
            end
        end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL mr_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_init_disabled;
        n_req1 = 1'b1; n_wr1 = 1'b1; n_addr1 = 5'd3; n_wdata1 = 4'h9;
        #1;
        compared++; if (n_busy !== 1'b0 || n_ram_write !== 1'b0) begin mismatched++; $display("FAIL ni_reset: got b%b w%b want b0 w0", n_busy, n_ram_write); end
        @(posedge clk); #1;
        rst2 = 1'b0;
        #1;
        compared++; if (n_gnt1 !== 1'b1 || n_gnt0 !== 1'b0) begin mismatched++; $display("FAIL ni_gnt: got g0=%b g1=%b want 0 1", n_gnt0, n_gnt1); end
        compared++; if (n_busy !== 1'b0) begin mismatched++; $display("FAIL ni_busy: got %b want 0", n_busy); end
        @(posedge clk); #1;
        n_req1 = 1'b0;
        compared++; if (n_ram_write !== 1'b1 || n_ram_address !== 5'd3 || n_ram_data !== 4'h9) begin mismatched++; $display("FAIL ni_cmd: got w%b a%0d d%h want w1 a3 d9", n_ram_write, n_ram_address, n_ram_data); end
        compared++; if (n_rvalid0 !== 1'b0 || n_rvalid1 !== 1'b0 || n_rdata0 !== 4'h0 || n_rdata1 !== 4'h0) begin mismatched++; $display("FAIL ni_rvalid: got %b%b %h %h want 00 0 0", n_rvalid0, n_rvalid1, n_rdata0, n_rdata1); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_round_robin;
        test_contention_write;
        test_reset_mid_read;
        test_init_disabled;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ram32x4_arbiter.md
# ram32x4_arbiter

Two-port round-robin arbiter and initialiser for the single-port 32 x 4 synchronous RAM (`ram32x4`: registered address/data/wren, unregistered q). It sits between two requesters, e.g. a switch/KEY user port and an automated test/scan engine, and the RAM. After reset it clears every word to `INIT_VALUE`. It then grants at most one read or write command per clock and returns read data with a fixed two-cycle latency.

## Interface
- `ADDR_WIDTH`, default 5: RAM address width (depth = 2^ADDR_WIDTH).
- `DATA_WIDTH`, default 4: RAM word width.
- `INIT_ENABLE`, default 1: 1 = run the clear sweep after reset; 0 = go straight to RUN.
- `INIT_VALUE`, default 0: word written to every address during the sweep.
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `Clock`, input, 1: the single clock; all state changes on the rising edge.
  - `Reset`, input, 1: asynchronous, active-high reset.
- Requester ports (n = 0, 1):
  - `Req0` / `Req1`, input, 1: command valid; must be held stable until granted.
  - `Wr0` / `Wr1`, input, 1: 1 = write, 0 = read.
  - `Addr0` / `Addr1`, input, ADDR_WIDTH: command address.
  - `WData0` / `WData1`, input, DATA_WIDTH: write data.
  - `Gnt0` / `Gnt1`, output, 1: combinational; the command transfers on the edge where Req&&Gnt.
  - `RValid0` / `RValid1`, output, 1: registered; one-cycle pulse, read data valid.
  - `RData0` / `RData1`, output, DATA_WIDTH: equal to `RamQ` while the matching RValid is high, 0 otherwise.
- Controller status and RAM side:
  - `Busy`, output, 1: high during reset and the init sweep.
  - `RamAddress`, output, ADDR_WIDTH: registered; drives `ram32x4` address.
  - `RamData`, output, DATA_WIDTH: registered; drives `ram32x4` data.
  - `RamWrite`, output, 1: registered; drives `ram32x4` wren.
  - `RamQ`, input, DATA_WIDTH: `ram32x4` q.

## Operation
- **States:** INIT, RUN.
- **Reset:** state = INIT (RUN if INIT_ENABLE=0). Init counter = 0, priority pointer = port 0. All outputs are 0 except `Busy`=1 (Busy=0 if INIT_ENABLE=0). The read-return pipeline is flushed.
- **INIT:**
  - Each cycle, register RamWrite=1, RamAddress=counter, RamData=INIT_VALUE, then increment the counter.
  - `Gnt0`=`Gnt1`=0 throughout.
  - After issuing address 2^ADDR_WIDTH-1, go to RUN. `Busy` falls on the same edge.
  - The sweep issues exactly 32 writes (default), addresses 0..31 in order.
- **RUN arbitration (combinational on the current inputs):**
  - Only one requester active: grant it.
  - Both active: grant the port the pointer favours.
  - On every transfer, the pointer moves to favour the other port. With no transfer, the pointer holds.
- **Transfer edge:** register RamAddress/RamData/RamWrite from the granted port. RamWrite=0 for reads, and RamData then holds its previous value.
  - Idle cycle (no transfer): RamWrite=0; address and data hold.
- **Read return:** a 2-stage owner/valid shift register tracks each accepted read.
  - Stage 2 drives `RValid`n high for one cycle. `RData`n = `RamQ`.
- **Throughput:** one command per cycle, back-to-back, including alternating ports and read-after-write to the same address.
- **Ordering:** a read accepted the cycle after a write to the same address returns the new data, because the RAM commits the write one edge before it samples the read address.
- **Reset mid-operation:** in-flight reads are discarded (no RValid is issued) and the INIT sweep restarts from address 0.

## Timing
- Accept edge E0 → RAM samples the command at E1 → `RValid`n high for the cycle after E1.
  - Read latency = 2 edges from acceptance.
  - The write is committed in the RAM at E1.
- `Gnt` depends combinationally on `Req0`/`Req1` and state. No Gnt→Req loop is allowed on the requester side.
- `Busy` deasserts exactly 2^ADDR_WIDTH edges after `Reset` falls (INIT_ENABLE=1).
- A requester holding Req through INIT is granted in the first RUN cycle.

## Test plan
- **Reset + init:** release Reset with Req0=1. Required response: Busy=1 for 32 cycles with RamWrite=1 and RamAddress 0..31 with RamData=0; Gnt0=0 throughout; Gnt0=1 in the first RUN cycle. Then read all 32 addresses via port 0; every RData0 must be 0.
- **Write/read latency:** port 0 writes 0xA to address 5, then the next cycle reads address 5. Required response: RValid0 is a single pulse 2 cycles after the read is accepted, with RData0=0xA; RValid1 stays 0.
- **Round robin:** hold Req0=Req1=1 with reads for 6 cycles. Required response: grants alternate 0,1,0,1,0,1 and each RValid pulse is routed to its owner. Then drop Req1; port 0 must be granted every cycle.
- **Contention write:** in the same cycle, port 0 writes 0x3 and port 1 writes 0xC, both to address 31. The pointer favours port 1. Required response: a later read of address 31 returns 0x3.
- **Reset mid-read:** accept a read, then assert Reset 1 cycle later. Required response: no RValid is issued, and Busy and the sweep restart from address 0.
- **INIT_ENABLE=0:** after reset, Busy=0 and Req1 is granted on the first cycle.
